// File: rtl/dram_write_pattern_if.sv
// dram_write_pattern_if: Avalon-MM burst write bus between the pattern writer and DRAM
interface dram_write_pattern_if #(
  parameter int MAXBURST_LOG   = 4,
  parameter int DRAM_ADDRSPACE = 32,
  parameter int DRAM_DATAWIDTH = 512
);
  logic                          AVALON_MM_WAITREQUEST;
  logic                          AVALON_MM_WRITEACK;
  logic [DRAM_ADDRSPACE-1:0]     AVALON_MM_ADDRESS;
  logic                          AVALON_MM_WRITE;
  logic                          AVALON_MM_READ;
  logic [DRAM_DATAWIDTH-1:0]     AVALON_MM_WRITEDATA;
  logic [DRAM_DATAWIDTH/8-1:0]   AVALON_MM_BYTEENABLE;
  logic [MAXBURST_LOG:0]         AVALON_MM_BURSTCOUNT;
  modport master (
    input  AVALON_MM_WAITREQUEST, AVALON_MM_WRITEACK,
    output AVALON_MM_ADDRESS, AVALON_MM_WRITE, AVALON_MM_READ,
           AVALON_MM_WRITEDATA, AVALON_MM_BYTEENABLE, AVALON_MM_BURSTCOUNT
  );
  modport slave (
    output AVALON_MM_WAITREQUEST, AVALON_MM_WRITEACK,
    input  AVALON_MM_ADDRESS, AVALON_MM_WRITE, AVALON_MM_READ,
           AVALON_MM_WRITEDATA, AVALON_MM_BYTEENABLE, AVALON_MM_BURSTCOUNT
  );
endinterface

// File: rtl/dram_write_pattern.sv
// dram_write_pattern: Avalon-MM burst writer filling DRAM with an incrementing 32-bit word pattern
module dram_write_pattern #(
  parameter int MAXBURST_LOG   = 4,
  parameter int WRITENUM_SIZE  = 31,
  parameter int DRAM_ADDRSPACE = 32,
  parameter int DRAM_DATAWIDTH = 512,
  parameter int WORD_WIDTH     = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      WRITE_REQ,
  input  logic [DRAM_ADDRSPACE-1:0] WRITE_INITADDR,
  input  logic [WRITENUM_SIZE:0]    WRITE_NUM,
  input  logic [WORD_WIDTH-1:0]     WRITE_INITVAL,
  output logic                      WRITE_RDY,
  output logic                      WRITE_DONE,
  output logic [31:0]               WRITE_CYCLES,
  dram_write_pattern_if.master      avm
);
  localparam int ELEMS = DRAM_DATAWIDTH / WORD_WIDTH;
  localparam int NW    = WRITENUM_SIZE + 1;
  localparam int BW    = MAXBURST_LOG + 1;
  localparam int MAXB  = 1 << MAXBURST_LOG;
  localparam logic [DRAM_ADDRSPACE-1:0] STRIDE = DRAM_ADDRSPACE'((DRAM_DATAWIDTH / 8) << MAXBURST_LOG);
  typedef enum logic [1:0] {IDLE, SETUP, BURST} state_t;
  state_t                    state_q, state_d;
  logic [DRAM_ADDRSPACE-1:0] addr_q, addr_d;
  logic [DRAM_DATAWIDTH-1:0] data_q, data_d;
  logic [BW-1:0]             bc_q, bc_d, cnt_q, cnt_d, last_q, last_d;
  logic [NW-1:0]             left_q, left_d;
  logic                      wr_q, wr_d, done_q, done_d;
  logic [31:0]               cyc_q, cyc_d;
  logic                      accept, unused;
  assign accept = wr_q & ~avm.AVALON_MM_WAITREQUEST;
  assign unused = avm.AVALON_MM_WRITEACK;
  // Lanes carry the pattern directly; each accepted beat advances every lane by ELEMS.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    bc_d    = bc_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    last_d  = last_q;
    wr_d    = wr_q;
    done_d  = 1'b0;
    cyc_d   = (state_q == IDLE) ? cyc_q : cyc_q + 32'd1;
    case (state_q)
      IDLE: if (WRITE_REQ) begin
        cyc_d  = '0;
        done_d = (WRITE_NUM == '0);
        if (WRITE_NUM != '0) begin
          state_d = SETUP;
          addr_d  = WRITE_INITADDR;
          for (int j = 0; j < ELEMS; j++) data_d[j*WORD_WIDTH +: WORD_WIDTH] = WRITE_INITVAL + WORD_WIDTH'(j);
          left_d  = (WRITE_NUM >> MAXBURST_LOG) + NW'(|WRITE_NUM[MAXBURST_LOG-1:0]);
          last_d  = (WRITE_NUM[MAXBURST_LOG-1:0] == '0) ? BW'(MAXB) : BW'(WRITE_NUM[MAXBURST_LOG-1:0]);
        end
      end
      SETUP: begin
        bc_d    = (left_q == NW'(1)) ? last_q : BW'(MAXB);
        cnt_d   = bc_d;
        wr_d    = 1'b1;
        state_d = BURST;
      end
      BURST: if (accept) begin
        for (int j = 0; j < ELEMS; j++) data_d[j*WORD_WIDTH +: WORD_WIDTH] = data_q[j*WORD_WIDTH +: WORD_WIDTH] + WORD_WIDTH'(ELEMS);
        cnt_d = cnt_q - BW'(1);
        if (cnt_q == BW'(1)) begin
          wr_d    = 1'b0;
          addr_d  = addr_q + STRIDE;
          left_d  = left_q - NW'(1);
          state_d = (left_q > NW'(1)) ? SETUP : IDLE;
          done_d  = (left_q == NW'(1));
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      bc_q    <= '0;
      cnt_q   <= '0;
      left_q  <= '0;
      last_q  <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      bc_q    <= bc_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      cyc_q   <= cyc_d;
    end
  end
  assign WRITE_RDY                = (state_q == IDLE);
  assign WRITE_DONE               = done_q;
  assign WRITE_CYCLES             = cyc_q;
  assign avm.AVALON_MM_ADDRESS    = addr_q;
  assign avm.AVALON_MM_WRITE      = wr_q;
  assign avm.AVALON_MM_READ       = 1'b0;
  assign avm.AVALON_MM_WRITEDATA  = data_q;
  assign avm.AVALON_MM_BYTEENABLE = '1;
  assign avm.AVALON_MM_BURSTCOUNT = bc_q;
endmodule

// File: tb/tb_dram_write_pattern.sv
// tb_dram_write_pattern: randomized bench scoring every Avalon beat against a burst-stream model
module tb_dram_write_pattern;
  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         WRITE_REQ = 1'b0;
  logic [31:0]  WRITE_INITADDR = '0;
  logic [31:0]  WRITE_NUM = '0;
  logic [31:0]  WRITE_INITVAL = '0;
  logic         WRITE_RDY, WRITE_DONE;
  logic [31:0]  WRITE_CYCLES;
  dram_write_pattern_if bus ();
  dram_write_pattern dut (
    .CLK(CLK), .RST(RST), .WRITE_REQ(WRITE_REQ), .WRITE_INITADDR(WRITE_INITADDR),
    .WRITE_NUM(WRITE_NUM), .WRITE_INITVAL(WRITE_INITVAL), .WRITE_RDY(WRITE_RDY),
    .WRITE_DONE(WRITE_DONE), .WRITE_CYCLES(WRITE_CYCLES), .avm(bus.master)
  );
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]  addr;
    logic [4:0]   bc;
    logic [511:0] data;
    bit           last;
  } beat_t;
  beat_t exp_q[$];
  int passed = 0, total = 0;
  int jt, cur_num, cur_bursts, smode, stalls, nacc, start_cyc;
  int exp_done_cyc = -1, exp_cycles = 0, first_cyc = -1, gap_cyc = -1, rst_chk_cyc = -1;
  int obs_done_cyc, obs_cycles;
  bit job_active = 0, done_seen, write_seen;
  logic [511:0] obs_first, obs_last;
  logic [31:0]  obs_addr[$];
  int           obs_bc[$];

  function automatic logic [511:0] lanes(logic [31:0] v);
    logic [511:0] r;
    for (int j = 0; j < 16; j++) r[j*32 +: 32] = v + 32'(j);
    return r;
  endfunction

  task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // The DUT must emit exactly this beat stream: burst b of a job starts at addr + b*1 KiB.
  task automatic model_job(logic [31:0] a, int n, logic [31:0] v);
    for (int k = 0; k < n; k++) begin
      beat_t b;
      int rem = n - 16 * (k / 16);
      b.addr = a + 32'(k / 16) * 32'h400;
      b.bc   = 5'(rem >= 16 ? 16 : rem);
      b.data = lanes(v + 32'(16 * k));
      b.last = (k % 16 == 15) || (k == n - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge CLK);
      if (cyc == rst_chk_cyc) begin
        chk("rst_write", bus.AVALON_MM_WRITE, 0);
        chk("rst_rdy", WRITE_RDY, 1);
        chk("rst_cycles", WRITE_CYCLES, 0);
      end
      if (cyc == exp_done_cyc) begin
        chk("done", WRITE_DONE, 1);
        chk("cycles", WRITE_CYCLES, exp_cycles);
        chk("done_write", bus.AVALON_MM_WRITE, 0);
        obs_done_cyc = cyc;
        obs_cycles   = WRITE_CYCLES;
        done_seen    = 1;
        job_active   = 0;
        exp_done_cyc = -1;
      end else chk("no_done", WRITE_DONE, 0);
      chk("rdy", WRITE_RDY, !(job_active && cyc > start_cyc));
      if (cyc == first_cyc) chk("latency", bus.AVALON_MM_WRITE, 1);
      if (cyc == gap_cyc) chk("gap", bus.AVALON_MM_WRITE, 0);
      if (cyc == gap_cyc + 1 && gap_cyc >= 0) chk("gap_end", bus.AVALON_MM_WRITE, 1);
      if (bus.AVALON_MM_WRITE) begin
        write_seen = 1;
        if (exp_q.size() == 0) chk("spurious_write", bus.AVALON_MM_WRITE, 0);
        else begin
          chk("addr", bus.AVALON_MM_ADDRESS, exp_q[0].addr);
          chk("burstcount", bus.AVALON_MM_BURSTCOUNT, exp_q[0].bc);
          chk("data", bus.AVALON_MM_WRITEDATA, exp_q[0].data);
          if (bus.AVALON_MM_WAITREQUEST) stalls++;
          else begin
            beat_t b = exp_q.pop_front();
            if (nacc % 16 == 0) begin
              obs_addr.push_back(bus.AVALON_MM_ADDRESS);
              obs_bc.push_back(int'(bus.AVALON_MM_BURSTCOUNT));
            end
            nacc++;
            if (nacc == 1) obs_first = bus.AVALON_MM_WRITEDATA;
            obs_last = bus.AVALON_MM_WRITEDATA;
            if (b.last && exp_q.size() > 0) gap_cyc = cyc + 1;
            if (exp_q.size() == 0) begin
              exp_done_cyc = cyc + 1;
              exp_cycles   = cur_num + cur_bursts + stalls;
            end
          end
        end
      end
    end
  endtask

  task automatic set_wr();
    bus.AVALON_MM_WAITREQUEST = (smode == 1) ? (cyc >= jt + 4 && cyc <= jt + 6) :
                                (smode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
    WRITE_REQ = (smode == 0 && cur_num >= 8 && cyc == jt + 5);
  endtask

  task automatic start_job(logic [31:0] a, int n, logic [31:0] v, int sm);
    int k = 0;
    while (!WRITE_RDY && k < 200) begin @(posedge CLK); #1; k++; end
    @(posedge CLK); #1;
    jt = cyc; smode = sm; stalls = 0; nacc = 0; write_seen = 0; done_seen = 0;
    obs_done_cyc = -1; obs_cycles = -1; obs_addr.delete(); obs_bc.delete();
    cur_num = n; cur_bursts = (n + 15) / 16; gap_cyc = -1;
    model_job(a, n, v);
    if (n != 0) begin
      job_active = 1; start_cyc = jt; first_cyc = jt + 2;
    end else begin
      exp_done_cyc = jt + 1; exp_cycles = 0;
    end
    bus.AVALON_MM_WAITREQUEST = 1'b0;
    WRITE_REQ = 1'b1; WRITE_INITADDR = a; WRITE_NUM = 32'(n); WRITE_INITVAL = v;
    @(posedge CLK); #1;
    WRITE_REQ = 1'b0; WRITE_INITADDR = $urandom; WRITE_NUM = $urandom; WRITE_INITVAL = $urandom;
  endtask

  task automatic finish_job();
    int k = 0;
    set_wr();
    while (!done_seen && k < 3000) begin @(posedge CLK); #1; set_wr(); k++; end
    bus.AVALON_MM_WAITREQUEST = 1'b0;
    WRITE_REQ = 1'b0;
    chk("done_seen", done_seen, 1);
    chk("beats", nacc, cur_num);
    if (done_seen) chk("cycles_span", obs_cycles, obs_done_cyc - jt - 1);
  endtask

  task automatic job(logic [31:0] a, int n, logic [31:0] v, int sm);
    start_job(a, n, v, sm);
    finish_job();
  endtask

  initial begin
    bus.AVALON_MM_WAITREQUEST = 1'b0;
    bus.AVALON_MM_WRITEACK = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_rdy", WRITE_RDY, 1);
    chk("reset_done", WRITE_DONE, 0);
    chk("reset_cycles", WRITE_CYCLES, 0);
    chk("reset_write", bus.AVALON_MM_WRITE, 0);
    chk("reset_addr", bus.AVALON_MM_ADDRESS, 0);
    chk("reset_bc", bus.AVALON_MM_BURSTCOUNT, 0);
    chk("reset_data", bus.AVALON_MM_WRITEDATA, 0);
    chk("reset_be", bus.AVALON_MM_BYTEENABLE, {64{1'b1}});
    chk("reset_read", bus.AVALON_MM_READ, 0);
    RST = 1'b0;
    fork monitor(); join_none
    job(32'h0, 16, 32'd1, 0);
    chk("t1_b0_lane0", obs_first[31:0], 1);
    chk("t1_b0_lane15", obs_first[511:480], 16);
    chk("t1_b15_lane0", obs_last[31:0], 241);
    chk("t1_done_cyc", obs_done_cyc, jt + 18);
    chk("t1_cycles", obs_cycles, 17);
    chk("t1_bc", obs_bc[0], 16);
    chk("t1_addr", obs_addr[0], 0);
    job(32'h0, 37, 32'd1, 0);
    chk("t2_nbursts", obs_addr.size(), 3);
    chk("t2_addr1", obs_addr[1], 32'h400);
    chk("t2_addr2", obs_addr[2], 32'h800);
    chk("t2_bc0", obs_bc[0], 16);
    chk("t2_bc2", obs_bc[2], 5);
    chk("t2_last_lane0", obs_last[31:0], 577);
    job(32'h0, 20, 32'd1, 1);
    chk("t3_cycles", obs_cycles, 25);
    chk("t3_stalls", stalls, 3);
    job(32'h40, 0, 32'd9, 0);
    chk("t4_done_cyc", obs_done_cyc, jt + 1);
    chk("t4_cycles", obs_cycles, 0);
    chk("t4_no_write", write_seen, 0);
    job(32'h0, 1, 32'hFFFF_FFF8, 0);
    chk("t5_lane7", obs_first[255:224], 32'hFFFF_FFFF);
    chk("t5_lane8", obs_first[287:256], 0);
    chk("t5_bc", obs_bc[0], 1);
    start_job(32'h1000, 48, 32'd5, 0);
    repeat (5) begin @(posedge CLK); #1; end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    exp_q.delete();
    job_active = 0; exp_done_cyc = -1; first_cyc = -1; gap_cyc = -1;
    rst_chk_cyc = cyc;
    @(posedge CLK); #1;
    job(32'h2000, 3, 32'd100, 0);
    chk("t6_addr", obs_addr[0], 32'h2000);
    chk("t6_lane0", obs_first[31:0], 100);
    for (int i = 0; i < 12; i++) begin
      int n = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 50));
      job($urandom & 32'hFFFF_FC00, n, $urandom, 2);
    end
    repeat (3) @(posedge CLK);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
